// File: rtl/mux8_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux8_scan_sequencer
// Description : Scans the enabled channels of an external 8-way mux, waits for
//               the bus to settle and presents each sample on a valid/ready
//               port. The optional XOR frame checksum is built only when
//               SCAN_CHKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mux8_scan_sequencer #(
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    input  logic [7:0]        ch_mask,
    input  logic [DATA_W-1:0] mux_o,
    output logic              S1,
    output logic              S2,
    output logic              S3,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        chan_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef SCAN_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] chksum,
    output logic              chksum_valid
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        mask_q;
    logic              cont_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        chan_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    // Result is {found, channel}: lowest enabled channel numbered >= from.
    function automatic logic [3:0] find_from(input logic [7:0] mask, input int from);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    logic [3:0] w_start_first;
    logic [3:0] w_wrap_first;
    logic [3:0] w_next;
    logic       w_hs;
    logic       cont_d;

    assign w_start_first = find_from(ch_mask, 0);
    assign w_wrap_first  = find_from(mask_q, 0);
    assign w_next        = find_from(mask_q, int'(sel_q) + 1);
    assign w_hs          = (state_q == ST_HOLD) && valid_q && out_ready;
    // A stop arriving on the final handshake edge already prevents the wrap.
    assign cont_d        = cont_q && !stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            mask_q  <= 8'd0;
            cont_q  <= 1'b0;
            data_q  <= '0;
            chan_q  <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                cont_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_q <= ch_mask;
                        cont_q <= cont && !stop;
                        if (!w_start_first[3]) begin
                            done_q <= 1'b1;
                        end else begin
                            sel_q   <= w_start_first[2:0];
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        data_q  <= mux_o;
                        chan_q  <= sel_q;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_hs) begin
                        valid_q <= 1'b0;
                        if (w_next[3]) begin
                            sel_q   <= w_next[2:0];
                            cnt_q   <= '0;
                            state_q <= ST_SETTLE;
                        end else if (cont_d) begin
                            sel_q   <= w_wrap_first[2:0];
                            cnt_q   <= '0;
                            state_q <= ST_SETTLE;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign {S3, S2, S1} = sel_q;
    assign data_out     = data_q;
    assign chan_out     = chan_q;
    assign out_valid    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef SCAN_CHKSUM_EN
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] chksum_q;
    logic              chksum_valid_q;

    assign acc_d = acc_q ^ data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q          <= '0;
            chksum_q       <= '0;
            chksum_valid_q <= 1'b0;
        end else begin
            chksum_valid_q <= 1'b0;
            if (w_hs) begin
                if (!w_next[3]) begin
                    chksum_q       <= acc_d;
                    chksum_valid_q <= 1'b1;
                    acc_q          <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    end

    assign chksum       = chksum_q;
    assign chksum_valid = chksum_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux8_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux8_scan_sequencer
// Description : Directed and randomized frames for mux8_scan_sequencer, checked
//               against a channel-list model and a table-driven mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        stop;
    logic [7:0]  ch_mask;
    logic [15:0] mux_o;
    logic        S1, S2, S3;
    logic [15:0] data_out;
    logic [2:0]  chan_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef SCAN_CHKSUM_EN
    logic [15:0] chksum;
    logic        chksum_valid;
`endif

    logic [15:0] mux_tbl [8];
    logic [2:0]  exp_q [$];
    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int valid_cycles = 0;

    mux8_scan_sequencer #(.DATA_W(16), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
        .ch_mask(ch_mask), .mux_o(mux_o), .S1(S1), .S2(S2), .S3(S3),
        .data_out(data_out), .chan_out(chan_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
`ifdef SCAN_CHKSUM_EN
        , .chksum(chksum), .chksum_valid(chksum_valid)
`endif
    );

    always #5 clk = ~clk;
    assign mux_o = mux_tbl[{S3, S2, S1}];

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (out_valid === 1'b1) valid_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a frame emits the enabled channels in ascending order.
    task automatic enqueue_frame(input logic [7:0] m);
        for (int c = 0; c < 8; c++) if (m[c]) exp_q.push_back(3'(c));
    endtask

    task automatic start_frame(input logic [7:0] m, input logic c, input logic s);
        ch_mask = m; cont = c; stop = s; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0; stop = 1'b0;
        ch_mask = 8'($urandom);
    endtask

    task automatic take_sample(input logic [2:0] ch, input int stall);
        int guard;
        logic [15:0] exp_d;
        guard = 0;
        exp_d = mux_tbl[ch];
        while (out_valid !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        check("valid_wait", 32'(out_valid), 32'd1);
        check("chan_out", 32'(chan_out), 32'(ch));
        check("data_out", 32'(data_out), 32'(exp_d));
        check("sel", 32'({S3, S2, S1}), 32'(ch));
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int s = 0; s < stall; s++) begin
            mux_tbl[ch] = ~exp_d;
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(data_out), 32'(exp_d));
            check("hold_chan", 32'(chan_out), 32'(ch));
            check("hold_sel", 32'({S3, S2, S1}), 32'(ch));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mux_tbl[ch] = exp_d;
        check("valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic finish_frame(input int d0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        tick();
        check("done_clear", 32'(done), 32'd0);
        tick();
        check("done_count", 32'(done_seen - d0), 32'd1);
    endtask

    task automatic run_queue(input int first_stall, input int max_stall);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            take_sample(exp_q.pop_front(),
                        (n == 0 && first_stall > 0) ? first_stall : $urandom_range(0, max_stall));
            n++;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_sel"}, 32'({S3, S2, S1}), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_chan"}, 32'(chan_out), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog expired");
    end

    initial begin
        int d0;
        int v0;
        logic [7:0] m;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; stop = 1'b0;
        ch_mask = 8'd0; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) mux_tbl[i] = 16'h1000 + 16'(i);
        tick(); tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        // Full scan, including the two-edge start-to-valid latency.
        d0 = done_seen;
        start_frame(8'hFF, 1'b0, 1'b0);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid0", 32'(out_valid), 32'd0);
        check("lat_sel", 32'({S3, S2, S1}), 32'd0);
        tick();
        check("lat_valid1", 32'(out_valid), 32'd1);
        enqueue_frame(8'hFF);
        run_queue(0, 0);
        finish_frame(d0);

        // Sparse mask with a five-cycle stall on ch2.
        for (int i = 0; i < 8; i++) mux_tbl[i] = 16'($urandom);
        d0 = done_seen;
        start_frame(8'b1010_0100, 1'b0, 1'b0);
        enqueue_frame(8'b1010_0100);
        run_queue(5, 0);
        finish_frame(d0);

        // Empty mask: immediate done, no sample.
        d0 = done_seen; v0 = valid_cycles;
        start_frame(8'h00, 1'b0, 1'b0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        tick();
        check("empty_done_clear", 32'(done), 32'd0);
        tick(); tick();
        check("empty_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("empty_done_count", 32'(done_seen - d0), 32'd1);

        // Continuous 0,7,0,7 then stop during ch0 with a start that must be ignored.
        d0 = done_seen;
        start_frame(8'h81, 1'b1, 1'b0);
        repeat (2) enqueue_frame(8'h81);
        run_queue(0, 2);
        v0 = 0;
        while (out_valid !== 1'b1 && v0 < 40) begin tick(); v0++; end
        check("cont_wrap_ch", 32'(chan_out), 32'd0);
        stop = 1'b1; start = 1'b1; ch_mask = 8'hFF;
        tick();
        stop = 1'b0; start = 1'b0;
        take_sample(3'd0, 0);
        take_sample(3'd7, 0);
        finish_frame(d0);
        tick(); tick();
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_valid", 32'(out_valid), 32'd0);

        // Same-edge start+stop latches cont=0: a single one-shot frame.
        d0 = done_seen;
        start_frame(8'h10, 1'b1, 1'b1);
        take_sample(3'd4, 1);
        finish_frame(d0);

        // Single channel in continuous mode, stopped during its SETTLE.
        d0 = done_seen;
        start_frame(8'h20, 1'b1, 1'b0);
        repeat (3) take_sample(3'd5, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        take_sample(3'd5, 0);
        finish_frame(d0);

        // Randomized one-shot frames with random back-pressure.
        repeat (8) begin
            for (int i = 0; i < 8; i++) mux_tbl[i] = 16'($urandom);
            m = 8'($urandom_range(1, 255));
            d0 = done_seen;
            start_frame(m, 1'b0, 1'b0);
            enqueue_frame(m);
            run_queue(0, 3);
            finish_frame(d0);
            repeat ($urandom_range(0, 2)) tick();
        end

`ifdef SCAN_CHKSUM_EN
        mux_tbl[0] = 16'hA5A5; mux_tbl[1] = 16'h0F0F;
        d0 = done_seen;
        start_frame(8'h03, 1'b0, 1'b0);
        take_sample(3'd0, 0);
        check("chk_quiet", 32'(chksum_valid), 32'd0);
        take_sample(3'd1, 0);
        check("chk_valid", 32'(chksum_valid), 32'd1);
        check("chk_value", 32'(chksum), 32'h0000_AAAA);
        finish_frame(d0);
        check("chk_pulse_end", 32'(chksum_valid), 32'd0);
`endif

        // Reset in the middle of a frame: no done pulse, everything zero.
        for (int i = 0; i < 8; i++) mux_tbl[i] = 16'h2000 + 16'(i);
        start_frame(8'hFF, 1'b0, 1'b0);
        take_sample(3'd0, 0);
        take_sample(3'd1, 0);
        d0 = done_seen;
        rst_n = 1'b0;
        tick();
        check_idle_zero("midreset");
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("midreset_no_done", 32'(done_seen - d0), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
